// File: rtl/baud_tick_gen_if.sv
// rtl/baud_tick_gen_if.sv - control and tick bundle for the baud tick generator
//
// Purpose: groups the runtime controls and the tick outputs of baud_tick_gen.
// Ports (signals):
//   enable        counters run when 1; hold and suppress ticks when 0
//   restart       1-cycle pulse, zero prescaler and oversample counter
//   div_load      1-cycle pulse, capture divisor
//   divisor       new divisor D (sample period = D+1 clocks)
//   sample_tick   1-cycle pulse every D+1 enabled clocks
//   mid_tick      1-cycle pulse at the middle of each bit
//   bit_tick      1-cycle pulse at the end of each bit
//   load_pending  deferred divisor load waiting for the next bit boundary
// master drives the controls and observes the ticks; slave is the generator.
interface baud_tick_gen_if #(
  parameter int DIV_W = 16
);
  logic             enable;
  logic             restart;
  logic             div_load;
  logic [DIV_W-1:0] divisor;
  logic             sample_tick;
  logic             mid_tick;
  logic             bit_tick;
  logic             load_pending;

  modport master (
    output enable, restart, div_load, divisor,
    input  sample_tick, mid_tick, bit_tick, load_pending
  );

  modport slave (
    input  enable, restart, div_load, divisor,
    output sample_tick, mid_tick, bit_tick, load_pending
  );
endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - programmable baud-rate tick generator for the UART datapath
//
// Purpose: divides in_clk into an oversample tick (every D+1 enabled clocks),
// a mid-bit tick and a bit-boundary tick (every OVERSAMPLE sample ticks).
// The divisor is runtime-loadable, either immediately or deferred to the next
// bit boundary, and the phase can be restarted for RX start-bit alignment.
// Ports:
//   in_clk   system clock, rising edge
//   reset    asynchronous active-low reset
//   bus      baud_tick_gen_if slave: enable/restart/div_load/divisor in,
//            sample_tick/mid_tick/bit_tick/load_pending out (all registered)
module baud_tick_gen #(
  parameter int DIV_W       = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 107,
  parameter int LOAD_AT_BIT = 0
) (
  input  logic              in_clk,
  input  logic              reset,
  baud_tick_gen_if.slave    bus
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam bit DEFER = (LOAD_AT_BIT != 0);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] prescaler;
  logic [OS_W-1:0]  os_cnt;
  logic             pending;
  logic             sample_q;
  logic             mid_q;
  logic             bit_q;

  // The prescaler only wraps through the equality compare, so any divisor up
  // to all-ones is safe without an overflow guard.
  wire fire    = (prescaler == div_reg);
  wire at_last = (os_cnt == OS_LAST);

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      div_reg   <= DIV_W'(DEFAULT_DIV);
      shadow    <= '0;
      prescaler <= '0;
      os_cnt    <= '0;
      pending   <= 1'b0;
      sample_q  <= 1'b0;
      mid_q     <= 1'b0;
      bit_q     <= 1'b0;
    end else begin
      sample_q <= 1'b0;
      mid_q    <= 1'b0;
      bit_q    <= 1'b0;

      if (bus.restart) begin
        // Restart realigns the phase and suppresses any tick due this edge.
        // A load arriving together with restart, or one already waiting,
        // takes effect now since the bit boundary it waited for is gone.
        prescaler <= '0;
        os_cnt    <= '0;
        if (bus.div_load) begin
          div_reg <= bus.divisor;
          pending <= 1'b0;
        end else if (pending) begin
          div_reg <= shadow;
          pending <= 1'b0;
        end
      end else if (bus.div_load && !DEFER) begin
        div_reg   <= bus.divisor;
        prescaler <= '0;
      end else if (bus.enable) begin
        if (fire) begin
          prescaler <= '0;
          os_cnt    <= os_cnt + 1'b1;
          sample_q  <= 1'b1;
          mid_q     <= (os_cnt == OS_MID);
          bit_q     <= at_last;
          if (at_last && pending) begin
            div_reg <= shadow;
            pending <= 1'b0;
          end
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end

      // Deferred load: placed last so a load on the same edge as the bit
      // boundary stays pending for the following bit.
      if (DEFER && bus.div_load && !bus.restart) begin
        shadow  <= bus.divisor;
        pending <= 1'b1;
      end
    end
  end

  assign bus.sample_tick  = sample_q;
  assign bus.mid_tick     = mid_q;
  assign bus.bit_tick     = bit_q;
  assign bus.load_pending = pending;
endmodule
